// File: rtl/pipe_pkg.sv
// Shared definitions for the 16-bit pipeline: opcodes, branch conditions,
// hazard-controller states and instruction field helpers.
package pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
    OP_XOR  = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
    OP_LW   = 4'h8, OP_SW  = 4'h9, OP_LUI = 4'hA, OP_LLI = 4'hB,
    OP_B    = 4'hC, OP_JAL = 4'hD, OP_JR  = 4'hE, OP_EXEC = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    CC_EQ = 3'b000, CC_NE = 3'b001, CC_GT = 3'b010, CC_LT = 3'b011,
    CC_GE = 3'b100, CC_LE = 3'b101, CC_VS = 3'b110, CC_AL = 3'b111
  } cond_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Instruction field slices: opcode[15:12] rd[11:8] rs[7:4] rt[3:0] cond[11:9]
  function automatic opcode_t f_opc(input logic [15:0] instr);
    return opcode_t'(instr[15:12]);
  endfunction

  function automatic logic [3:0] f_rd(input logic [15:0] instr);
    return instr[11:8];
  endfunction

  function automatic logic [3:0] f_rs(input logic [15:0] instr);
    return instr[7:4];
  endfunction

  function automatic logic [3:0] f_rt(input logic [15:0] instr);
    return instr[3:0];
  endfunction

  function automatic cond_t f_cond(input logic [15:0] instr);
    return cond_t'(instr[11:9]);
  endfunction

  // Operand usage and side effects by opcode
  function automatic logic uses_rs(input opcode_t opc);
    return opc <= OP_SW;
  endfunction

  function automatic logic uses_rt(input opcode_t opc);
    return opc <= OP_OR;
  endfunction

  function automatic logic uses_rd(input opcode_t opc);
    return (opc == OP_SW) || (opc == OP_JR) || (opc == OP_EXEC);
  endfunction

  function automatic logic writes_reg(input opcode_t opc);
    return (opc <= OP_LW) || (opc == OP_LUI) || (opc == OP_LLI) || (opc == OP_JAL);
  endfunction

  function automatic logic sets_flags(input opcode_t opc);
    return opc <= OP_SHR;
  endfunction

  // Branch condition evaluated on an {N,V,Z} flag triple
  function automatic logic cond_true(input cond_t c, input logic [2:0] nvz);
    logic n, v, z, res;
    n = nvz[2];
    v = nvz[1];
    z = nvz[0];
    case (c)
      CC_EQ:   res = z;
      CC_NE:   res = ~z;
      CC_GT:   res = ~z & ~n;
      CC_LT:   res = n;
      CC_GE:   res = z | ~n;
      CC_LE:   res = z | n;
      CC_VS:   res = v;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher over the in-flight scoreboard: reports the youngest
// stage whose destination equals the source register. R0 never matches.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RSIZE = 4,
  parameter int SEL_W = 2
) (
  input  logic [RSIZE-1:0]            src,
  input  logic [DEPTH:1]              v,
  input  logic [DEPTH:1]              ld,
  input  logic [DEPTH:1][RSIZE-1:0]   dest,
  output logic                        hit,
  output logic [SEL_W-1:0]            sel,
  output logic                        is_load
);

  // Scan oldest to youngest so the youngest match overwrites and wins
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    hit     = 1'b0;
    sel     = '0;
    is_load = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if ((src != '0) && v[k] && (dest[k] == src)) begin
        hit     = 1'b1;
        sel     = SEL_W'(k);
        is_load = ld[k];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage hazard and flow controller: tracks in-flight destinations,
// selects forwarding sources, raises load-use / flag-hazard stalls,
// resolves branches on registered flags and flushes fetch after redirects.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter  int ISIZE      = 16,
  parameter  int RSIZE      = 4,
  parameter  int FWD_DEPTH  = 2,
  parameter  int BR_PENALTY = 1,
  parameter  int LINK_REG   = 15,
  localparam int FSEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ISIZE-1:0]  id_instr,
  input  logic [2:0]        alu_flags,
  input  logic              alu_flag_we,
  output logic              stall,
  output logic              flush,
  output logic              pc_redirect,
  output logic              br_taken,
  output logic [FSEL_W-1:0] fwd_rs,
  output logic [FSEL_W-1:0] fwd_rt,
  output logic [FSEL_W-1:0] fwd_rd
);

  localparam int                CNT_W    = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(BR_PENALTY - 1);
  localparam logic [RSIZE-1:0]  LINK     = RSIZE'(LINK_REG);
  localparam logic [FSEL_W-1:0] SEL_EX   = FSEL_W'(1);

  state_t                        state, state_n;
  logic [CNT_W-1:0]              cnt, cnt_n;
  logic [2:0]                    flags;
  logic [FWD_DEPTH:1]            sb_v, sb_ld, sb_fl;
  logic [FWD_DEPTH:1][RSIZE-1:0] sb_dest;

  opcode_t          opc;
  logic [RSIZE-1:0] rd, rs, rt;
  logic             active, use_rs, use_rt, use_rd;
  logic             load_use, flag_haz, issue;
  logic             rs_hit, rt_hit, rd_hit, rs_ld, rt_ld, rd_ld;
  logic [FSEL_W-1:0] rs_sel, rt_sel, rd_sel;

  assign opc    = f_opc(id_instr);
  assign rd     = f_rd(id_instr);
  assign rs     = f_rs(id_instr);
  assign rt     = f_rt(id_instr);
  assign use_rs = uses_rs(opc);
  assign use_rt = uses_rt(opc);
  assign use_rd = uses_rd(opc);

  fwd_match #(.DEPTH(FWD_DEPTH), .RSIZE(RSIZE), .SEL_W(FSEL_W)) u_match_rs (
    .src(rs), .v(sb_v), .ld(sb_ld), .dest(sb_dest),
    .hit(rs_hit), .sel(rs_sel), .is_load(rs_ld)
  );

  fwd_match #(.DEPTH(FWD_DEPTH), .RSIZE(RSIZE), .SEL_W(FSEL_W)) u_match_rt (
    .src(rt), .v(sb_v), .ld(sb_ld), .dest(sb_dest),
    .hit(rt_hit), .sel(rt_sel), .is_load(rt_ld)
  );

  fwd_match #(.DEPTH(FWD_DEPTH), .RSIZE(RSIZE), .SEL_W(FSEL_W)) u_match_rd (
    .src(rd), .v(sb_v), .ld(sb_ld), .dest(sb_dest),
    .hit(rd_hit), .sel(rd_sel), .is_load(rd_ld)
  );

  // ID is only considered in RUN and outside reset; FLUSH ignores id_valid
  assign active = ~rst & (state == ST_RUN) & id_valid;

  // A load sitting in EX cannot forward yet: hold ID for one cycle
  assign load_use = active & ((use_rs & rs_hit & rs_ld & (rs_sel == SEL_EX)) |
                              (use_rt & rt_hit & rt_ld & (rt_sel == SEL_EX)) |
                              (use_rd & rd_hit & rd_ld & (rd_sel == SEL_EX)));

  // Branch must wait until a flag-setting EX instruction has written the flag copy
  assign flag_haz = active & (opc == OP_B) & sb_v[1] & sb_fl[1];

  assign stall       = load_use | flag_haz;
  assign issue       = active & ~stall;
  assign br_taken    = issue & (opc == OP_B) & cond_true(f_cond(id_instr), flags);
  assign pc_redirect = br_taken | (issue & ((opc == OP_JAL) | (opc == OP_JR)));
  assign flush       = ~rst & (state == ST_FLUSH);

  assign fwd_rs = (active & use_rs & rs_hit) ? rs_sel : '0;
  assign fwd_rt = (active & use_rt & rt_hit) ? rt_sel : '0;
  assign fwd_rd = (active & use_rd & rd_hit) ? rd_sel : '0;

  // Next state: enter FLUSH on redirect, leave it the cycle after the counter hits zero
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_RUN: begin
        if (pc_redirect) begin
          state_n = ST_FLUSH;
          cnt_n   = CNT_INIT;
        end
      end
      ST_FLUSH: begin
        if (cnt == '0) state_n = ST_RUN;
        else           cnt_n   = cnt - CNT_W'(1);
      end
    endcase
  end

  // State, flag copy and scoreboard shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole scoreboard is cleared so no stale hazard survives a reset mid-stall.
      state   <= ST_RUN;
      cnt     <= '0;
      flags   <= '0;
      sb_v    <= '0;
      sb_ld   <= '0;
      sb_fl   <= '0;
      sb_dest <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage shift from its pre-edge value.
      state <= state_n;
      cnt   <= cnt_n;
      if (alu_flag_we) flags <= alu_flags;
      for (int k = FWD_DEPTH; k >= 2; k--) begin
        sb_v[k]    <= sb_v[k-1];
        sb_ld[k]   <= sb_ld[k-1];
        sb_fl[k]   <= sb_fl[k-1];
        sb_dest[k] <= sb_dest[k-1];
      end
      sb_v[1]    <= issue & writes_reg(opc);
      sb_ld[1]   <= issue & (opc == OP_LW);
      sb_fl[1]   <= issue & sets_flags(opc);
      sb_dest[1] <= (opc == OP_JAL) ? LINK : rd;
    end
  end

endmodule
